// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: data width, RV32I load/store size codes, FSM state encoding
// and the byte-lane mask helper used by the request path.
package all_pkgs;

   localparam int WIDTH = 32;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } lsu_state_t;

   // funct3[1:0] alone selects the access size for every legal code
   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   lane_mask = 4'b0001 << off;
         2'b01:   lane_mask = 4'b0011 << off;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory port: single outstanding request held until ack,
// read data valid only in the ack cycle.
interface load_store_unit_if #(
   parameter int WIDTH = all_pkgs::WIDTH
);
   logic             dmem_req;
   logic             dmem_we;
   logic [WIDTH-1:0] dmem_addr;
   logic [3:0]       dmem_be;
   logic [WIDTH-1:0] dmem_wdata;
   logic             dmem_ack;
   logic [WIDTH-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/load_store_unit_extend.sv
// Combinational load lane select and sign/zero extension (zero latency,
// no flow control).
module load_extend
   import all_pkgs::*;
#(
   parameter int WIDTH = all_pkgs::WIDTH
) (
   input  logic [WIDTH-1:0] rdata,
   input  logic [1:0]       offset,
   input  logic [2:0]       funct3,
   output logic [WIDTH-1:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (offset)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         LS_B:    result = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
         LS_BU:   result = {{(WIDTH-8){1'b0}}, byte_lane};
         LS_H:    result = {{(WIDTH-16){half_lane[15]}}, half_lane};
         LS_HU:   result = {{(WIDTH-16){1'b0}}, half_lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access at a time; result two cycles after issue with
// immediate ack. Upstream is stalled from issue until ack; faults never stall.
module load_store_unit
   import all_pkgs::*;
#(
   parameter int WIDTH   = all_pkgs::WIDTH,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ex_valid,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [2:0]          funct3,
   input  logic [WIDTH-1:0]    addr,
   input  logic [WIDTH-1:0]    store_data,
   output logic                stall,
   output logic [WIDTH-1:0]    mem_data,
   output logic                mem_data_valid,
   output logic                lsu_fault,
   load_store_unit_if.master   dmem
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t       state_q, state_d;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] sdata_q;
   logic [2:0]       f3_q;
   logic             we_q;
   logic [CW-1:0]    cnt_q;
   logic             fault_q;

   logic             legal;
   logic             aligned;
   logic             accept;
   logic             reject;
   logic             timeout;
   logic [WIDTH-1:0] ext_data;

   // Request qualification in IDLE
   always_comb begin
      if (mem_write)
         legal = (funct3 == LS_B) || (funct3 == LS_H) || (funct3 == LS_W);
      else
         legal = (funct3 == LS_B) || (funct3 == LS_H) || (funct3 == LS_W) ||
                 (funct3 == LS_BU) || (funct3 == LS_HU);

      case (funct3)
         LS_B, LS_BU: aligned = 1'b1;
         LS_H, LS_HU: aligned = ~addr[0];
         LS_W:        aligned = (addr[1:0] == 2'b00);
         default:     aligned = 1'b0;
      endcase
   end

   assign accept  = (state_q == IDLE) && ex_valid && (mem_read ^ mem_write) && legal && aligned;
   assign reject  = (state_q == IDLE) && ex_valid && (mem_read || mem_write) &&
                    !((mem_read ^ mem_write) && legal && aligned);
   assign timeout = (state_q == REQ) && !dmem.dmem_ack && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = REQ;
         REQ: begin
            if (dmem.dmem_ack)
               state_d = DONE;
            else if (timeout)
               state_d = IDLE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus fields come only from latched state so they hold steady until ack
   always_comb begin
      stall           = accept || (state_q == REQ);
      mem_data_valid  = (state_q == DONE);
      lsu_fault       = fault_q;
      dmem.dmem_req   = (state_q == REQ);
      dmem.dmem_we    = we_q;
      dmem.dmem_addr  = {addr_q[WIDTH-1:2], 2'b00};
      dmem.dmem_be    = lane_mask(f3_q, addr_q[1:0]);
      case (f3_q[1:0])
         2'b00:   dmem.dmem_wdata = {4{sdata_q[7:0]}};
         2'b01:   dmem.dmem_wdata = {2{sdata_q[15:0]}};
         default: dmem.dmem_wdata = sdata_q;
      endcase
   end

   load_extend #(.WIDTH(WIDTH)) u_extend (
      .rdata  (dmem.dmem_rdata),
      .offset (addr_q[1:0]),
      .funct3 (f3_q),
      .result (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mem_data <= '0;
         fault_q  <= 1'b0;
         addr_q   <= '0;
         sdata_q  <= '0;
         f3_q     <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= reject || timeout;
         if (accept) begin
            addr_q  <= addr;
            sdata_q <= store_data;
            f3_q    <= funct3;
            we_q    <= mem_write;
            cnt_q   <= '0;
         end else if ((state_q == REQ) && !dmem.dmem_ack) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if ((state_q == REQ) && dmem.dmem_ack && !we_q)
            mem_data <= ext_data;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit; expected bus requests and
// result/fault pulses are queued at issue and checked by independent monitors.
module tb_load_store_unit;
   import all_pkgs::*;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wd;
   } req_t;

   typedef struct {
      logic        v;      // 1 = mem_data_valid, 0 = lsu_fault
      logic [31:0] md;
      int          cyc;
   } out_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ex_valid = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic        stall;
   logic [31:0] mem_data;
   logic        mem_data_valid;
   logic        lsu_fault;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   req_t req_q[$];
   out_t out_q[$];

   load_store_unit_if #(.WIDTH(32)) dmem ();

   load_store_unit #(.WIDTH(32), .TIMEOUT(255)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .funct3         (funct3),
      .addr           (addr),
      .store_data     (store_data),
      .stall          (stall),
      .mem_data       (mem_data),
      .mem_data_valid (mem_data_valid),
      .lsu_fault      (lsu_fault),
      .dmem           (dmem)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Request monitor: checks bus fields at the first cycle of each dmem_req
   initial begin
      logic req_prev;
      req_t r;
      req_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && dmem.dmem_req && !req_prev) begin
            if (req_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dmem_req_unexpected: got req addr %h expected none", dmem.dmem_addr);
            end else begin
               r = req_q.pop_front();
               chk("dmem_addr", dmem.dmem_addr, r.addr);
               chk("dmem_be", {28'd0, dmem.dmem_be}, {28'd0, r.be});
               chk("dmem_we", {31'd0, dmem.dmem_we}, {31'd0, r.we});
               if (r.we)
                  chk("dmem_wdata", dmem.dmem_wdata, r.wd);
            end
         end
         req_prev = dmem.dmem_req;
      end
   end

   // Output monitor: every valid or fault pulse must match the next expectation
   initial begin
      out_t o;
      forever begin
         @(negedge clk);
         if (rst_n && (mem_data_valid || lsu_fault)) begin
            if (out_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL output_unexpected: got valid=%0b fault=%0b data %h expected no pulse",
                        mem_data_valid, lsu_fault, mem_data);
            end else begin
               o = out_q.pop_front();
               chk("pulse_kind", {30'd0, mem_data_valid, lsu_fault}, {30'd0, o.v, ~o.v});
               chk("mem_data", mem_data, o.md);
               chk("pulse_cycle", cyc, o.cyc);
            end
         end
      end
   end

   // dly >= 0: ack after dly wait cycles; dly < 0: ack withheld until timeout
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                         input int dly, input logic ok, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] md);
      int n;
      @(posedge clk);
      #1;
      n = cyc;
      ex_valid = 1'b1; mem_read = rd; mem_write = wr;
      funct3 = f3; addr = a; store_data = sd;
      if (ok) begin
         req_q.push_back('{addr: {a[31:2], 2'b00}, be: be, we: wr, wd: wd});
         if (dly >= 0) out_q.push_back('{v: 1'b1, md: md, cyc: n + 2 + dly});
         else          out_q.push_back('{v: 1'b0, md: md, cyc: n + 256});
      end else begin
         out_q.push_back('{v: 1'b0, md: md, cyc: n + 1});
      end
      @(negedge clk);
      chk("stall_issue", {31'd0, stall}, {31'd0, ok});
      @(posedge clk);
      #1;
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      if (ok && dly >= 0) begin
         for (int k = 0; k <= dly; k++) begin
            if (k > 0) begin
               @(posedge clk);
               #1;
            end
            if (k == dly) begin
               dmem.dmem_ack = 1'b1;
               dmem.dmem_rdata = rdat;
            end
            if (k == 0) begin
               @(negedge clk);
               chk("stall_wait", {31'd0, stall}, 32'd1);
            end
         end
         @(posedge clk);
         #1;
         dmem.dmem_ack = 1'b0;
         dmem.dmem_rdata = '0;
         @(negedge clk);
         chk("stall_done", {31'd0, stall}, 32'd0);
      end else if (ok) begin
         @(negedge clk);
         chk("stall_wait", {31'd0, stall}, 32'd1);
         repeat (255) @(posedge clk);
         #1;
         @(negedge clk);
         chk("stall_after_timeout", {31'd0, stall}, 32'd0);
         chk("req_after_timeout", {31'd0, dmem.dmem_req}, 32'd0);
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mem_data", mem_data, 32'd0);
      chk("rst_valid", {31'd0, mem_data_valid}, 32'd0);
      chk("rst_fault", {31'd0, lsu_fault}, 32'd0);
      chk("rst_dmem_req", {31'd0, dmem.dmem_req}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      //      rd   wr   f3      addr        sd            rdata         dly ok  be       wdata         mem_data
      access(1'b1, 1'b0, LS_B,  32'h103, 32'h0,        32'h80FF_1234, 0, 1'b1, 4'b1000, 32'h0,        32'hFFFF_FF80);
      access(1'b1, 1'b0, LS_HU, 32'h102, 32'h0,        32'h8001_0000, 0, 1'b1, 4'b1100, 32'h0,        32'h0000_8001);
      access(1'b1, 1'b0, LS_H,  32'h102, 32'h0,        32'h8001_0000, 1, 1'b1, 4'b1100, 32'h0,        32'hFFFF_8001);
      access(1'b0, 1'b1, LS_B,  32'h201, 32'h0000_00AB, 32'h0,        0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'hFFFF_8001);
      access(1'b1, 1'b0, LS_W,  32'h102, 32'h0,        32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001);
      access(1'b1, 1'b0, LS_W,  32'h100, 32'h0,        32'hDEAD_BEEF, 3, 1'b1, 4'b1111, 32'h0,        32'hDEAD_BEEF);
      access(1'b0, 1'b1, LS_H,  32'h202, 32'h1234_CDEF, 32'h0,        0, 1'b1, 4'b1100, 32'hCDEF_CDEF, 32'hDEAD_BEEF);
      access(1'b0, 1'b1, LS_W,  32'h204, 32'h0123_4567, 32'h0,        2, 1'b1, 4'b1111, 32'h0123_4567, 32'hDEAD_BEEF);
      access(1'b1, 1'b0, LS_BU, 32'h101, 32'h0,        32'h0000_A500, 0, 1'b1, 4'b0010, 32'h0,        32'h0000_00A5);
      access(1'b1, 1'b0, LS_B,  32'h102, 32'h0,        32'h007F_0000, 0, 1'b1, 4'b0100, 32'h0,        32'h0000_007F);
      access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0,       32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);
      access(1'b0, 1'b1, LS_BU, 32'h100, 32'h0,        32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);
      access(1'b1, 1'b1, LS_W,  32'h100, 32'h0,        32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);
      access(1'b1, 1'b0, LS_H,  32'h101, 32'h0,        32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);
      access(1'b0, 1'b1, LS_H,  32'h203, 32'h0,        32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);
      access(1'b1, 1'b0, LS_W,  32'h100, 32'h0,        32'h0,        -1, 1'b1, 4'b1111, 32'h0,        32'h0000_007F);

      // Stray ack while idle must not produce a result
      @(posedge clk);
      #1;
      dmem.dmem_ack = 1'b1;
      dmem.dmem_rdata = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = '0;
      @(negedge clk);
      chk("idle_ack_mem_data", mem_data, 32'h0000_007F);

      // Reset in the middle of an outstanding access
      @(posedge clk);
      #1;
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = LS_W; addr = 32'h100;
      req_q.push_back('{addr: 32'h100, be: 4'b1111, we: 1'b0, wd: 32'h0});
      @(posedge clk);
      #1;
      ex_valid = 1'b0; mem_read = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("req_before_reset", {31'd0, dmem.dmem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_req_async", {31'd0, dmem.dmem_req}, 32'd0);
      chk("reset_mem_data", mem_data, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      dmem.dmem_ack = 1'b1;
      dmem.dmem_rdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = '0;
      @(negedge clk);
      chk("late_ack_mem_data", mem_data, 32'd0);

      access(1'b1, 1'b0, LS_W,  32'h108, 32'h0,        32'h1122_3344, 0, 1'b1, 4'b1111, 32'h0,        32'h1122_3344);

      repeat (5) @(posedge clk);
      chk("req_queue_drained", req_q.size(), 32'd0);
      chk("out_queue_drained", out_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WIDTH, default all_pkgs::WIDTH (32), data/address width; WIDTH SHALL be 32.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles waiting for dmem_ack before fault.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port ex_valid  input  1  memory instruction presented this cycle.
REQ-006 Port mem_read / mem_write  input  1 each  load / store request.
REQ-007 Port funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Port addr  input  WIDTH  byte address.
REQ-009 Port store_data  input  WIDTH  rs2 value for stores.
REQ-010 Port stall  output  1  freezes upstream pipeline while access is outstanding.
REQ-011 Port mem_data  output  WIDTH  aligned, extended load result driven to writeback select input 01.
REQ-012 Port mem_data_valid  output  1  one-cycle pulse when mem_data updates or store completes.
REQ-013 Port lsu_fault  output  1  one-cycle pulse: misaligned, illegal funct3, read+write together, or timeout.
REQ-014 Ports dmem_req, dmem_we  output  1 each; dmem_addr  output  WIDTH; dmem_be  output  4; dmem_wdata  output  WIDTH.
REQ-015 Ports dmem_ack  input  1; dmem_rdata  input  WIDTH (valid in ack cycle).

Function
REQ-016 FSM states SHALL be IDLE, REQ, DONE.
REQ-017 IDLE: ex_valid & (mem_read ^ mem_write) & legal & aligned SHALL latch addr, funct3, store_data, we, enter REQ; stall asserted combinationally that cycle.
REQ-018 Aligned: B always; H/HU require addr[0]=0; W requires addr[1:0]=00; funct3 011/110/111 on load, or >010 on store, is illegal.
REQ-019 Misaligned/illegal/both-set request in IDLE SHALL pulse lsu_fault next cycle, issue no dmem_req, never assert stall, remain IDLE.
REQ-020 REQ: dmem_req=1 held, with dmem_addr = {latched addr[WIDTH-1:2],2'b00}, dmem_we, dmem_be, dmem_wdata stable until dmem_ack; stall=1.
REQ-021 dmem_be: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111; loads SHALL also drive the matching mask.
REQ-022 dmem_wdata: B -> byte replicated x4; H -> halfword replicated x2; W -> store_data.
REQ-023 REQ with dmem_ack: load SHALL register extracted lane (byte at addr[1:0]*8, half at addr[1]*16), sign-extend for B/H, zero-extend for BU/HU, into mem_data; enter DONE.
REQ-024 REQ with dmem_ack on store: mem_data unchanged; enter DONE.
REQ-025 DONE: stall=0, mem_data_valid=1 for exactly this cycle, dmem_req=0; inputs ignored; next state IDLE unconditionally.
REQ-026 Minimum latency: request cycle N, ack at N+1, mem_data_valid at N+2; stall high cycles N and N+1.
REQ-027 Wait counter SHALL clear on REQ entry, increment each REQ cycle without ack; reaching TIMEOUT SHALL pulse lsu_fault, drop dmem_req, return IDLE, mem_data unchanged, no mem_data_valid.
REQ-028 dmem_ack outside REQ SHALL be ignored.
REQ-029 mem_data SHALL hold last load result until the next load completes.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, mem_data 0, mem_data_valid 0, lsu_fault 0, dmem_req 0, stall 0 (unless a new request is presented after release).
REQ-031 Reset during REQ SHALL abandon the access; a late dmem_ack after release SHALL be ignored.

Structure
REQ-032 all_pkgs SHALL hold WIDTH, funct3 size constants (LS_B, LS_H, LS_W, LS_BU, LS_HU) and enum lsu_state_t {IDLE, REQ, DONE}.
REQ-033 Lane select and extension SHALL be a combinational sub-module load_extend (rdata, offset[1:0], funct3 -> WIDTH result).

Verification
REQ-034 LB addr 0x103, rdata 0x80FF_1234, ack next cycle -> mem_data 0xFFFF_FF80, dmem_be 1000, valid at N+2.
REQ-035 LHU addr 0x102, rdata 0x8001_0000 -> mem_data 0x0000_8001; LH same -> 0xFFFF_8001.
REQ-036 SB addr 0x201, store_data 0x0000_00AB -> dmem_wdata 0xABAB_ABAB, dmem_be 0010, dmem_we 1, mem_data unchanged.
REQ-037 LW addr 0x102 -> lsu_fault pulse, dmem_req never asserted, stall 0.
REQ-038 LW addr 0x100, ack withheld 255 cycles -> lsu_fault, return IDLE, no mem_data_valid; repeat with rst_n low mid-REQ -> dmem_req falls asynchronously, mem_data 0.
